alu_server: RTL
===============

# alu_server

Sequential request/response wrapper around the 16-bit ALU function set. It accepts operations over a valid/ready request channel, computes them in a registered stage, and returns results with the overflow flag through a small output FIFO that tolerates response backpressure. It sits between an issuing master (sequencer or bench driver) and the rest of the datapath, and responds in-order to every accepted request.

## Interface
- DATA_WIDTH, 16, operand/result width
- DEPTH, 4, output FIFO entries (power of two, ≥2)
- clk  input  1  rising-edge clock
- reset_n  input  1  asynchronous, active-low reset
- req_valid  input  1  request present
- req_ready  output  1  server can accept request this cycle
- req_a  input  DATA_WIDTH  operand A
- req_b  input  DATA_WIDTH  operand B
- req_func  input  4  function code (alu_func.v encoding)
- rsp_valid  output  1  FIFO head valid
- rsp_ready  input  1  consumer takes head this cycle
- rsp_c  output  DATA_WIDTH  result at FIFO head
- rsp_of  output  1  overflow flag at FIFO head
- op_cnt  output  16  accepted requests, wraps at 16'hffff→0
- ovf_cnt  output  16  results with OF=1, saturates at 16'hffff

## Operation
- Function codes: 0 ADD, 1 SUB, 2 ID, 3 NOT, 4 AND, 5 OR, 6 NAND, 7 NOR, 8 XOR, 9 XNOR, 10 LLS, 11 LRS, 12 ALS, 13 ARS, 14 TCP, 15 ZERO.
- ADD/SUB: modulo-2^16 result; OF = signed overflow (operands same sign for ADD / differing sign for SUB, result sign differs from A). All other codes: OF=0.
- LLS/ALS: A<<1, zero-fill. LRS: A>>1, zero-fill. ARS: A>>1, replicate A[15]. TCP: ~A+1. ID: A. NOT: ~A. ZERO: 0. B ignored by unary/shift codes.
- Accept: handshake when req_valid && req_ready at a rising edge; operands and func are captured into stage S1 (s1_valid=1).
- Compute: at the next edge, S1 contents are evaluated and the result {C,OF} pushed into the FIFO; ovf_cnt increments (saturating) if OF=1.
- Credit: req_ready = (fifo_count + s1_valid) < DEPTH, computed from current registered state only; a same-cycle pop does not raise req_ready. No FIFO overflow is possible by construction.
- Response: rsp_valid = fifo_count != 0; head popped when rsp_valid && rsp_ready. Simultaneous push and pop keeps count unchanged; pointers wrap modulo DEPTH.
- Order: responses are strictly in acceptance order.
- op_cnt increments on every request handshake.

## Timing
- Reset (asserted asynchronously, any time): req_ready=1, rsp_valid=0, rsp_c=0, rsp_of=0, op_cnt=0, ovf_cnt=0, s1_valid=0, FIFO empty; in-flight S1 op and FIFO contents are discarded, and no response is emitted for them after release.
- Latency: request accepted at edge k → result enters FIFO at edge k+1 → if FIFO was empty, rsp_valid=1 with that result during the cycle after k+1 (2-edge latency).
- Throughput: one request per cycle while rsp_ready=1 held high (steady state: count ≤1, s1_valid=1).
- rsp_c/rsp_of hold stable while rsp_valid=1 and rsp_ready=0.
- Full: with rsp_ready=0, exactly DEPTH requests are accepted; req_ready drops in the cycle after the DEPTH-th handshake (S1 + FIFO account for DEPTH).
- rsp_c/rsp_of are 0 when FIFO is empty.

## Test plan
- Single ops: ADD 7fff+0005 → C=8004, OF=1; SUB 7fff-ffff → 8000, OF=1; ARS f001 → f800, OF=0; TCP f0f1 → 0f0f, OF=0; rsp_valid rises 2 edges after handshake.
- All 16 codes streamed back-to-back with rsp_ready=1 (ADD 0001+0001 … ZERO abcd): 16 in-order responses on 16 consecutive cycles, results matching the function table, op_cnt=16.
- Backpressure: rsp_ready=0, req_valid=1 continuously → exactly 4 handshakes, req_ready=0 afterwards; release rsp_ready → 4 in-order responses, then acceptance resumes; no loss or duplication.
- Simultaneous push/pop at full: fifo count stays constant, req_ready remains 0 that cycle, data order preserved across pointer wrap (≥10 ops).
- Counters: 3 overflowing ADDs (8000+8001) + 2 clean ops → ovf_cnt=3, op_cnt=5; force ovf_cnt near 16'hffff via long overflow run → saturates at ffff.
- Reset mid-operation: assert reset_n=0 with S1 valid and 2 FIFO entries → outputs go to reset values immediately (no clock); after release, no stale responses are emitted and a fresh ADD 0fff+0001 → 1000.

Source files
------------

// File: rtl/alu_server.sv
// ---------------------------------------------------------------------------
// alu_server
//
// Request/response wrapper around the 16-bit ALU function set. A request
// accepted on the valid/ready channel is captured into a single register
// stage (S1), evaluated on the following edge and the {result, overflow}
// pair is pushed into a small output FIFO. Responses leave the FIFO
// strictly in acceptance order and tolerate backpressure on rsp_ready.
//
// Admission is credit based: a request is only accepted while the FIFO
// occupancy plus the S1 occupancy is below DEPTH, so the FIFO can never
// overflow. All outputs are registered; their next values are derived
// from the next-state of the pipeline.
//
// Ports
//   clk        rising-edge clock
//   reset_n    asynchronous active-low reset
//   req_valid  request present
//   req_ready  server can accept a request this cycle
//   req_a      operand A
//   req_b      operand B
//   req_func   function code (0 ADD .. 15 ZERO)
//   rsp_valid  FIFO head valid
//   rsp_ready  consumer takes the head this cycle
//   rsp_c      result at FIFO head (0 when empty)
//   rsp_of     overflow flag at FIFO head (0 when empty)
//   op_cnt     accepted requests, wrapping
//   ovf_cnt    results with overflow set, saturating at 16'hffff
// ---------------------------------------------------------------------------
module alu_server #(
    parameter int DATA_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic [3:0]            req_func,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_c,
    output logic                  rsp_of,
    output logic [15:0]           op_cnt,
    output logic [15:0]           ovf_cnt
);

    localparam int PTR_W = (DEPTH > 2) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = PTR_W + 1;
    // One extra bit so that fifo_count + s1_valid cannot wrap.
    localparam int SUM_W = CNT_W + 1;
    localparam int MSB   = DATA_WIDTH - 1;

    localparam logic [3:0] FN_ADD  = 4'd0;
    localparam logic [3:0] FN_SUB  = 4'd1;
    localparam logic [3:0] FN_ID   = 4'd2;
    localparam logic [3:0] FN_NOT  = 4'd3;
    localparam logic [3:0] FN_AND  = 4'd4;
    localparam logic [3:0] FN_OR   = 4'd5;
    localparam logic [3:0] FN_NAND = 4'd6;
    localparam logic [3:0] FN_NOR  = 4'd7;
    localparam logic [3:0] FN_XOR  = 4'd8;
    localparam logic [3:0] FN_XNOR = 4'd9;
    localparam logic [3:0] FN_LLS  = 4'd10;
    localparam logic [3:0] FN_LRS  = 4'd11;
    localparam logic [3:0] FN_ALS  = 4'd12;
    localparam logic [3:0] FN_ARS  = 4'd13;
    localparam logic [3:0] FN_TCP  = 4'd14;
    localparam logic [3:0] FN_ZERO = 4'd15;

    // ALU evaluation: returns {of, c}. Only ADD/SUB can flag overflow.
    function automatic logic [DATA_WIDTH:0] alu_eval(
        input logic [DATA_WIDTH-1:0] a,
        input logic [DATA_WIDTH-1:0] b,
        input logic [3:0]            func
    );
        logic [DATA_WIDTH-1:0] c;
        logic                  of;
        c  = {DATA_WIDTH{1'b0}};
        of = 1'b0;
        case (func)
            FN_ADD: begin
                c  = a + b;
                of = (a[MSB] == b[MSB]) && (c[MSB] != a[MSB]);
            end
            FN_SUB: begin
                c  = a - b;
                of = (a[MSB] != b[MSB]) && (c[MSB] != a[MSB]);
            end
            FN_ID:   c = a;
            FN_NOT:  c = ~a;
            FN_AND:  c = a & b;
            FN_OR:   c = a | b;
            FN_NAND: c = ~(a & b);
            FN_NOR:  c = ~(a | b);
            FN_XOR:  c = a ^ b;
            FN_XNOR: c = ~(a ^ b);
            FN_LLS:  c = {a[MSB-1:0], 1'b0};
            FN_LRS:  c = {1'b0, a[MSB:1]};
            FN_ALS:  c = {a[MSB-1:0], 1'b0};
            FN_ARS:  c = {a[MSB], a[MSB:1]};
            FN_TCP:  c = ~a + {{(DATA_WIDTH-1){1'b0}}, 1'b1};
            FN_ZERO: c = {DATA_WIDTH{1'b0}};
            default: c = {DATA_WIDTH{1'b0}};
        endcase
        return {of, c};
    endfunction

    // Pipeline stage S1
    logic                  s1_valid_r;
    logic [DATA_WIDTH-1:0] s1_a_r;
    logic [DATA_WIDTH-1:0] s1_b_r;
    logic [3:0]            s1_func_r;

    // Output FIFO, stored as {of, c}
    logic [DATA_WIDTH:0]   mem_r [DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;

    // Registered outputs
    logic                  req_ready_r;
    logic                  rsp_valid_r;
    logic [DATA_WIDTH-1:0] rsp_c_r;
    logic                  rsp_of_r;
    logic [15:0]           op_cnt_r;
    logic [15:0]           ovf_cnt_r;

    // Next-state helpers
    logic                  accept_s;
    logic                  push_s;
    logic                  pop_s;
    logic [DATA_WIDTH:0]   result_s;
    logic [CNT_W-1:0]      count_next_s;
    logic [PTR_W-1:0]      rd_ptr_next_s;
    logic [SUM_W-1:0]      credit_next_s;
    logic                  ready_next_s;
    logic [DATA_WIDTH:0]   head_next_s;

    assign accept_s = req_valid && req_ready_r;
    assign push_s   = s1_valid_r;
    assign pop_s    = rsp_valid_r && rsp_ready;
    assign result_s = alu_eval(s1_a_r, s1_b_r, s1_func_r);

    // FIFO occupancy and read pointer after this edge.
    always_comb begin
        count_next_s  = count_r;
        rd_ptr_next_s = rd_ptr_r;
        case ({push_s, pop_s})
            2'b10:   count_next_s = count_r + CNT_W'(1'b1);
            2'b01:   count_next_s = count_r - CNT_W'(1'b1);
            default: count_next_s = count_r;
        endcase
        if (pop_s) begin
            rd_ptr_next_s = rd_ptr_r + PTR_W'(1'b1);
        end else begin
            rd_ptr_next_s = rd_ptr_r;
        end
    end

    // Credit check on the next registered state; S1 is full after an accept.
    always_comb begin
        credit_next_s = {1'b0, count_next_s} + {{CNT_W{1'b0}}, accept_s};
        ready_next_s  = (credit_next_s < SUM_W'(DEPTH));
    end

    // Next FIFO head. When the FIFO is empty (or its last entry leaves) and
    // S1 pushes, the fresh result bypasses the memory into the head register.
    always_comb begin
        head_next_s = {(DATA_WIDTH+1){1'b0}};
        if (count_next_s == {CNT_W{1'b0}}) begin
            head_next_s = {(DATA_WIDTH+1){1'b0}};
        end else if ((count_r == {CNT_W{1'b0}}) ||
                     (pop_s && (count_r == CNT_W'(1'b1)))) begin
            head_next_s = result_s;
        end else begin
            head_next_s = mem_r[rd_ptr_next_s];
        end
    end

    // S1 capture: loaded on handshake, drained unconditionally next edge.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            s1_valid_r <= 1'b0;
            s1_a_r     <= {DATA_WIDTH{1'b0}};
            s1_b_r     <= {DATA_WIDTH{1'b0}};
            s1_func_r  <= 4'd0;
        end else begin
            s1_valid_r <= accept_s;
            if (accept_s) begin
                s1_a_r    <= req_a;
                s1_b_r    <= req_b;
                s1_func_r <= req_func;
            end else begin
                s1_a_r    <= s1_a_r;
                s1_b_r    <= s1_b_r;
                s1_func_r <= s1_func_r;
            end
        end
    end

    // FIFO storage and pointers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {(DATA_WIDTH+1){1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (push_s) begin
                mem_r[wr_ptr_r] <= result_s;
                wr_ptr_r        <= wr_ptr_r + PTR_W'(1'b1);
            end else begin
                wr_ptr_r        <= wr_ptr_r;
            end
            rd_ptr_r <= rd_ptr_next_s;
            count_r  <= count_next_s;
        end
    end

    // Registered handshake and response outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            req_ready_r <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_c_r     <= {DATA_WIDTH{1'b0}};
            rsp_of_r    <= 1'b0;
        end else begin
            req_ready_r <= ready_next_s;
            rsp_valid_r <= (count_next_s != {CNT_W{1'b0}});
            rsp_c_r     <= head_next_s[DATA_WIDTH-1:0];
            rsp_of_r    <= head_next_s[DATA_WIDTH];
        end
    end

    // Statistics: op_cnt wraps, ovf_cnt saturates.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            op_cnt_r  <= 16'd0;
            ovf_cnt_r <= 16'd0;
        end else begin
            if (accept_s) begin
                op_cnt_r <= op_cnt_r + 16'd1;
            end else begin
                op_cnt_r <= op_cnt_r;
            end
            if (push_s && result_s[DATA_WIDTH] && (ovf_cnt_r != 16'hffff)) begin
                ovf_cnt_r <= ovf_cnt_r + 16'd1;
            end else begin
                ovf_cnt_r <= ovf_cnt_r;
            end
        end
    end

    assign req_ready = req_ready_r;
    assign rsp_valid = rsp_valid_r;
    assign rsp_c     = rsp_c_r;
    assign rsp_of    = rsp_of_r;
    assign op_cnt    = op_cnt_r;
    assign ovf_cnt   = ovf_cnt_r;

endmodule
